// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions.
// Major opcode constants and default datapath width.
package riscv_pkg;

   localparam int XLEN_DEFAULT = 32;

   localparam logic [4:0] OPC_BRANCH = 5'b11000;
   localparam logic [4:0] OPC_JAL    = 5'b11011;
   localparam logic [4:0] OPC_JALR   = 5'b11001;

endpackage

// File: rtl/bta_adder_slice.sv
// Ripple-carry adder slice used by the branch target unit.
// Carry in and carry out allow chaining across pipeline stages.
module bta_adder_slice #(
   parameter int W = 16
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout
);

   logic [W:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < W; i++) begin : g_fa
      assign sum[i]  = a[i] ^ b[i] ^ c[i];
      assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign cout = c[W];

endmodule

// File: rtl/branch_target_unit.sv
// EX-stage branch/jump target generator with link address,
// misalignment flag and 1- or 2-stage valid/ready pipeline.
module branch_target_unit
   import riscv_pkg::*;
#(
   parameter int XLEN         = XLEN_DEFAULT,
   parameter int STAGES       = 1,
   parameter int IMM_PRESHIFT = 1,
   parameter int C_EXT        = 0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [4:0]      opcode,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] imm,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] target,
   output logic [XLEN-1:0] link,
   output logic            misaligned,
   output logic            is_jump
);

   localparam int H = XLEN / 2;

   logic            is_jalr;
   logic            is_jmp;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic [XLEN-1:0] link_c;
   logic [XLEN-1:0] t_nxt;
   logic [XLEN-1:0] l_nxt;
   logic            j_nxt;
   logic            src_v;
   logic            ld_out;

   assign is_jalr = (opcode == OPC_JALR);
   assign is_jmp  = is_jalr || (opcode == OPC_JAL);
   assign op_a    = is_jalr ? rs1 : pc;
   assign op_b    = (is_jalr || IMM_PRESHIFT == 0) ? imm
                  : {imm[XLEN-2:0], 1'b0};
   assign link_c  = pc + XLEN'(4);
   assign ld_out  = !out_valid || out_ready;

   if (STAGES == 1) begin : g_one
      logic [XLEN-1:0] sum;
      logic            unused_cout;

      bta_adder_slice #(.W(XLEN)) u_add (
         .a    (op_a),
         .b    (op_b),
         .cin  (1'b0),
         .sum  (sum),
         .cout (unused_cout)
      );

      assign t_nxt    = {sum[XLEN-1:1], sum[0] & ~is_jalr};
      assign l_nxt    = link_c;
      assign j_nxt    = is_jmp;
      assign src_v    = in_valid;
      assign in_ready = ld_out;
   end else begin : g_two
      logic [H-1:0]    lo;
      logic [H-1:0]    lo_q;
      logic [H-1:0]    a_hi;
      logic [H-1:0]    b_hi;
      logic [H-1:0]    hi;
      logic            c;
      logic            c_q;
      logic            v1;
      logic            jmp_q;
      logic            ld1;
      logic            unused_cout;
      logic [XLEN-1:0] link_q;

      bta_adder_slice #(.W(H)) u_lo (
         .a    (op_a[H-1:0]),
         .b    (op_b[H-1:0]),
         .cin  (1'b0),
         .sum  (lo),
         .cout (c)
      );

      bta_adder_slice #(.W(H)) u_hi (
         .a    (a_hi),
         .b    (b_hi),
         .cin  (c_q),
         .sum  (hi),
         .cout (unused_cout)
      );

      assign ld1 = !v1 || ld_out;

      always_ff @(posedge clk) begin
         if (!rst_n)     v1 <= 1'b0;
         else if (flush) v1 <= 1'b0;
         else if (ld1)   v1 <= in_valid;
      end

      // Clearing bit 0 early is safe: the carry comes from the raw sum.
      always_ff @(posedge clk) begin
         if (ld1 && in_valid) begin
            lo_q   <= {lo[H-1:1], lo[0] & ~is_jalr};
            c_q    <= c;
            a_hi   <= op_a[XLEN-1:H];
            b_hi   <= op_b[XLEN-1:H];
            link_q <= link_c;
            jmp_q  <= is_jmp;
         end
      end

      assign t_nxt    = {hi, lo_q};
      assign l_nxt    = link_q;
      assign j_nxt    = jmp_q;
      assign src_v    = v1;
      assign in_ready = ld1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         target     <= '0;
         link       <= '0;
         misaligned <= 1'b0;
         is_jump    <= 1'b0;
      end else begin
         if (flush)       out_valid <= 1'b0;
         else if (ld_out) out_valid <= src_v;
         if (ld_out && src_v) begin
            target     <= t_nxt;
            link       <= l_nxt;
            misaligned <= (C_EXT == 0) && t_nxt[1];
            is_jump    <= j_nxt;
         end
      end
   end

endmodule

// File: tb/tb_branch_target_unit.sv
// Scoreboard bench for branch_target_unit: three configurations
// share one stimulus stream, each with its own expected-result queue.
module tb_branch_target_unit;
   import riscv_pkg::*;

   localparam int X = 32;

   typedef struct packed {
      logic [X-1:0] t;
      logic [X-1:0] l;
      logic         m;
      logic         j;
   } res_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         flush;
   logic         out_ready;
   logic [4:0]   opcode;
   logic [X-1:0] pc;
   logic [X-1:0] rs1;
   logic [X-1:0] imm;

   logic         rdy [3];
   logic         ov  [3];
   logic [X-1:0] tg  [3];
   logic [X-1:0] lk  [3];
   logic         ms  [3];
   logic         jp  [3];

   res_t q [3][$];
   res_t pv [3];
   logic stl [3];

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   branch_target_unit u0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
      .opcode(opcode), .pc(pc), .rs1(rs1), .imm(imm), .flush(flush),
      .out_valid(ov[0]), .out_ready(out_ready), .target(tg[0]),
      .link(lk[0]), .misaligned(ms[0]), .is_jump(jp[0])
   );

   branch_target_unit #(.STAGES(2)) u1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
      .opcode(opcode), .pc(pc), .rs1(rs1), .imm(imm), .flush(flush),
      .out_valid(ov[1]), .out_ready(out_ready), .target(tg[1]),
      .link(lk[1]), .misaligned(ms[1]), .is_jump(jp[1])
   );

   branch_target_unit #(.C_EXT(1)) u2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]),
      .opcode(opcode), .pc(pc), .rs1(rs1), .imm(imm), .flush(flush),
      .out_valid(ov[2]), .out_ready(out_ready), .target(tg[2]),
      .link(lk[2]), .misaligned(ms[2]), .is_jump(jp[2])
   );

   task automatic chk(input string tag, input logic [95:0] got,
                      input logic [95:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic res_t model(input logic [4:0] op,
                                  input logic [X-1:0] p,
                                  input logic [X-1:0] r,
                                  input logic [X-1:0] im,
                                  input int ce);
      res_t x;
      logic [X-1:0] s;
      if (op == OPC_JALR) begin
         s = r + im;
         s[0] = 1'b0;
      end else begin
         s = p + (im << 1);
      end
      x.t = s;
      x.l = p + 32'd4;
      x.m = (ce != 0) ? 1'b0 : s[1];
      x.j = (op == OPC_JALR) || (op == OPC_JAL);
      return x;
   endfunction

   function automatic logic exp_rdy(input int i, input int n);
      if (i == 1) return (n < 2) || out_ready;
      return (n == 0) || out_ready;
   endfunction

   task automatic evaluate();
      res_t cur;
      res_t e;
      int   n;
      for (int i = 0; i < 3; i++) begin
         cur.t = tg[i];
         cur.l = lk[i];
         cur.m = ms[i];
         cur.j = jp[i];
         n = q[i].size();
         if (stl[i] && ov[i])
            chk($sformatf("hold%0d", i), 96'(cur), 96'(pv[i]));
         chk($sformatf("in_ready%0d", i), 96'(rdy[i]), 96'(exp_rdy(i, n)));
         if (n == 0)
            chk($sformatf("stale%0d", i), 96'(ov[i]), 96'(0));
         else if (i != 1 || n == 2)
            chk($sformatf("out_valid%0d", i), 96'(ov[i]), 96'(1));
         if (ov[i] && out_ready && n != 0) begin
            e = q[i].pop_front();
            chk($sformatf("target%0d", i), 96'(tg[i]), 96'(e.t));
            chk($sformatf("link%0d", i), 96'(lk[i]), 96'(e.l));
            chk($sformatf("misal%0d", i), 96'(ms[i]), 96'(e.m));
            chk($sformatf("jump%0d", i), 96'(jp[i]), 96'(e.j));
         end
         if (!rst_n || flush)
            q[i].delete();
         else if (in_valid && rdy[i])
            q[i].push_back(model(opcode, pc, rs1, imm, (i == 2) ? 1 : 0));
         stl[i] = ov[i] && !out_ready;
         pv[i] = cur;
      end
   endtask

   task automatic step(input logic v, input logic [4:0] op,
                       input logic [X-1:0] p, input logic [X-1:0] r,
                       input logic [X-1:0] im, input logic fl,
                       input logic ordy);
      in_valid  = v;
      opcode    = op;
      pc        = p;
      rs1       = r;
      imm       = im;
      flush     = fl;
      out_ready = ordy;
      #1;
      evaluate();
      @(negedge clk);
   endtask

   task automatic idle(input int n, input logic ordy);
      for (int k = 0; k < n; k++) step(1'b0, 5'd0, '0, '0, '0, 1'b0, ordy);
   endtask

   task automatic chk_reset(input string tag);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("%s_ov%0d", tag, i), 96'(ov[i]), 96'(0));
         chk($sformatf("%s_tg%0d", tag, i), 96'(tg[i]), 96'(0));
         chk($sformatf("%s_rdy%0d", tag, i), 96'(rdy[i]), 96'(1));
      end
   endtask

   initial begin
      logic [4:0] op;
      rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      opcode = '0; pc = '0; rs1 = '0; imm = '0;
      for (int i = 0; i < 3; i++) stl[i] = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk_reset("rst");
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rst_lk%0d", i), 96'(lk[i]), 96'(0));
         chk($sformatf("rst_ms%0d", i), 96'(ms[i]), 96'(0));
         chk($sformatf("rst_jp%0d", i), 96'(jp[i]), 96'(0));
      end

      // Latency: one cycle for STAGES=1, two for STAGES=2.
      step(1'b1, OPC_BRANCH, 32'h0000_1000, '0, 32'h0000_0004, 1'b0, 1'b1);
      chk("lat1_u0", 96'(ov[0]), 96'(1));
      chk("lat1_u1", 96'(ov[1]), 96'(0));
      idle(1, 1'b1);
      chk("lat2_u1", 96'(ov[1]), 96'(1));
      idle(2, 1'b1);

      // Directed vectors, back to back.
      step(1'b1, OPC_BRANCH, 32'h0000_1000, '0, 32'h0000_0008, 1'b0, 1'b1);
      step(1'b1, OPC_JALR, '0, 32'h0000_2003, 32'hFFFF_FFFE, 1'b0, 1'b1);
      step(1'b1, OPC_JAL, 32'hFFFF_FFF0, '0, 32'h0000_0010, 1'b0, 1'b1);
      step(1'b1, OPC_JAL, 32'h0000_0000, '0, 32'h0000_0001, 1'b0, 1'b1);
      step(1'b1, OPC_BRANCH, 32'h0000_FFFC, '0, 32'h0000_0002, 1'b0, 1'b1);
      step(1'b1, 5'b01100, 32'h0000_0100, '0, 32'h0000_0003, 1'b0, 1'b1);
      step(1'b1, OPC_JALR, '0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b1);
      idle(3, 1'b1);

      // Four back-to-back requests with a 3-cycle output stall.
      for (int k = 0; k < 9; k++)
         step(k < 4, OPC_JAL, 32'h0000_FF00 + 32'(k * 16), '0,
              32'h0000_0080 + 32'(k), 1'b0, !(k >= 2 && k < 5));
      idle(3, 1'b1);

      // Flush with requests in flight plus a new offer.
      step(1'b1, OPC_BRANCH, 32'h0000_0200, '0, 32'h0000_0010, 1'b0, 1'b0);
      step(1'b1, OPC_JAL, 32'h0000_0300, '0, 32'h0000_0020, 1'b0, 1'b0);
      step(1'b1, OPC_JALR, '0, 32'h0000_0400, 32'h0000_0005, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++)
         chk($sformatf("flush_ov%0d", i), 96'(ov[i]), 96'(0));
      step(1'b1, OPC_BRANCH, 32'h0000_0500, '0, 32'h0000_0006, 1'b0, 1'b1);
      idle(3, 1'b1);

      // Random traffic with stalls and occasional flushes.
      for (int k = 0; k < 200; k++) begin
         case ($urandom_range(0, 3))
            0: op = OPC_BRANCH;
            1: op = OPC_JAL;
            2: op = OPC_JALR;
            default: op = 5'b00100;
         endcase
         step(($urandom_range(0, 3) != 0), op, $urandom, $urandom,
              $urandom, ($urandom_range(0, 15) == 0),
              ($urandom_range(0, 3) != 0));
      end
      idle(3, 1'b1);

      // Reset mid-operation with a full, stalled pipe.
      for (int k = 0; k < 3; k++)
         step(1'b1, OPC_JAL, 32'h0000_1000 * 32'(k + 1), '0, 32'h40,
              1'b0, 1'b0);
      rst_n = 1'b0;
      step(1'b1, OPC_JAL, 32'h0000_9000, '0, 32'h40, 1'b0, 1'b0);
      rst_n = 1'b1;
      #1;
      chk_reset("midrst");
      step(1'b1, OPC_BRANCH, 32'h0000_0040, '0, 32'h0000_0002, 1'b0, 1'b1);
      idle(4, 1'b1);

      for (int i = 0; i < 3; i++)
         chk($sformatf("drained%0d", i), 96'(q[i].size()), 96'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/branch_target_unit.md
Name: branch_target_unit

Overview:
- Pipelined, parametrised branch/jump target generator for the EX stage.
- Computes the redirect target for BRANCH and JAL (pc + imm) and for JALR ((rs1 + imm) with bit 0 cleared), plus the link address pc + 4.
- Flags misaligned targets; supports 1 or 2 pipeline stages and a valid/ready handshake with stall and flush.
- Its outputs drive the PC-redirect mux and the exception logic.

Parameters:
- XLEN, 32, datapath width in bits (must be even, ≥ 8).
- STAGES, 1, pipeline depth. 1 = single registered add. 2 = low half added in stage 1, high half plus carry in stage 2.
- IMM_PRESHIFT, 1, 1 = BRANCH/JAL immediate arrives without bit 0 and is shifted left by 1 internally; 0 = immediate is already byte-scaled. JALR imm is never shifted.
- C_EXT, 0, 1 = 16-bit alignment required; 0 = 32-bit alignment required.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request this cycle.
- opcode  in  5  instr[6:2].
- pc  in  XLEN  PC of the instruction.
- rs1  in  XLEN  rs1 operand (JALR base).
- imm  in  XLEN  sign-extended immediate.
- flush  in  1  kill all in-flight requests.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- target  out  XLEN  computed target.
- link  out  XLEN  pc + 4.
- misaligned  out  1  target violates alignment.
- is_jump  out  1  opcode was JAL or JALR (unconditional).

Behaviour:
- Reset (rst_n low at a clock edge): all stage valid bits = 0. After reset, out_valid = 0, target = 0, link = 0, misaligned = 0, is_jump = 0. in_ready = 1 in the first cycle after reset.
- Operand select:
  - opcode 11001 (JALR): A = rs1, B = imm.
  - opcode 11011 (JAL) or 11000 (BRANCH): A = pc, B = IMM_PRESHIFT ? imm << 1 : imm.
  - Any other opcode: accepted and computed as the BRANCH case with is_jump = 0. The caller decides whether to use the result.
- Arithmetic:
  - target = (A + B) mod 2^XLEN; carry out is discarded, so wrap-around is silent.
  - JALR: target[0] forced to 0 after the add.
  - link = pc + 4 mod 2^XLEN.
  - misaligned = C_EXT ? 0 : target[1]. For JALR it is evaluated after bit 0 is cleared.
- Latency:
  - STAGES = 1: a request accepted at edge N has its result on outputs after edge N, i.e. out_valid is high in cycle N+1.
  - STAGES = 2: results appear one cycle later.
  - Stage 1 registers sum[XLEN/2-1:0], the carry, and the upper operand halves. Stage 2 adds the upper halves plus the carry.
  - Throughput: 1 request/cycle when out_ready = 1.
- Handshake:
  - Transfer in when in_valid && in_ready. Transfer out when out_valid && out_ready.
  - A stage loads when it is empty or its downstream is loading/draining.
  - in_ready = !v1 || (downstream of stage 1 can take it), where downstream is the output register or stage 2.
  - in_ready is combinational from out_ready and the valid bits; there is no path from in_valid to in_ready.
  - Outputs hold stable while out_valid && !out_ready.
- Flush:
  - flush = 1 at an edge clears every valid bit.
  - An input offered in the same cycle is dropped (flush wins).
  - in_ready is unaffected by flush.
  - Data registers need not clear.
- Simultaneous drain + accept on a full pipe: both occur with no bubble.
- rst_n low mid-operation: the pipe empties at that edge regardless of flush or in_valid.

Decomposition:
- Shared package riscv_pkg holds:
  - opcode constants OPC_BRANCH = 5'b11000, OPC_JAL = 5'b11011, OPC_JALR = 5'b11001;
  - XLEN default.
- Sub-module bta_adder_slice (parameter W): ripple full-adder chain with cin and cout. It is instantiated once for STAGES = 1 (W = XLEN), twice for STAGES = 2 (W = XLEN/2 each).

Test Plan:
- Default params, out_ready = 1. BRANCH pc = 0x0000_1000, imm = 0x0000_0008 -> target 0x0000_1010, link 0x0000_1004, misaligned 0, is_jump 0, out_valid one cycle after accept.
- JALR rs1 = 0x0000_2003, imm = 0xFFFF_FFFE (−2) -> sum 0x2001, target 0x0000_2000, misaligned 0, is_jump 1.
- JAL pc = 0xFFFF_FFF0, imm = 0x0000_0010 (shifted to 0x20) -> target 0x0000_0010 (wrap), no error. Then JAL imm = 0x1 with pc = 0x0 -> target 0x2, misaligned 1. Repeat with C_EXT = 1 -> misaligned 0.
- STAGES = 2, back-to-back 4 requests, out_ready held 0 for 3 cycles mid-stream -> in_ready drops once both stages are full, outputs stable while stalled, all 4 results in order, no loss or duplication. Check a carry across the half boundary: pc = 0x0000_FFFC, imm = 0x2 (shifted 0x4) -> 0x0001_0000.
- Flush with 2 requests in flight plus a new in_valid in the same cycle -> out_valid 0 the next cycle, no stale result ever appears. The next request after the flush completes normally.
- Assert rst_n = 0 for one cycle with the pipe full and out_ready = 0 -> out_valid 0, target 0 the next cycle, in_ready 1.
